// File: rtl/cfa_bilinear3x3.sv
// cfa_bilinear3x3: 3x3 bilinear Bayer demosaic with two line buffers, a runtime Bayer phase
// and a sticky line-overflow flag; sync/den/RGB are delayed by exactly 3 clk.
module cfa_bilinear3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_vsync,
  input  logic              in_hsync,
  input  logic              in_den,
  input  logic [DATA_W-1:0] in_raw,
  input  logic [1:0]        cfg_pattern,
  output logic              out_vsync,
  output logic              out_hsync,
  output logic              out_den,
  output logic [DATA_W-1:0] out_data_R,
  output logic [DATA_W-1:0] out_data_G,
  output logic [DATA_W-1:0] out_data_B,
  output logic              line_overflow
);
  localparam int RAM_AW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] X_LIM = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0] X_MAX = '1;

  logic [ADDR_W-1:0]   x_q, x_d, s0_x_q;
  logic [1:0]          y_cnt_q, y_cnt_d, pat_q, s1_par_q, site;
  logic                y_par_q, y_par_d, den_fall, s0_in_buf, valid;
  logic                s0_vs_q, s0_hs_q, s0_den_q, s0_ypar_q, s0_yok_q;
  logic                s1_vs_q, s1_hs_q, s1_den_q, s1_ok_q, s1_ovf_q;
  logic [DATA_W-1:0]   s0_raw_q, s1_raw_q, rd0_q, rd1_q;
  logic [DATA_W-1:0]   lb0 [IMG_H];
  logic [DATA_W-1:0]   lb1 [IMG_H];
  logic [RAM_AW-1:0]   ra;
  logic [3*DATA_W-1:0] col0_q, col1_q, col_new;
  logic [DATA_W-1:0]   n, s, w, e, c, d0, d1, d2, d3;
  logic [DATA_W-1:0]   a_x, a_d, a_ns, a_we, r_d, g_d, b_d;

  // y only needs its parity and whether two lines have completed
  assign den_fall  = s0_den_q && !in_den;
  assign x_d       = !in_hsync ? '0 : (in_den && x_q != X_MAX) ? x_q + 1'b1 : x_q;
  assign y_par_d   = in_vsync && (y_par_q ^ den_fall);
  assign y_cnt_d   = !in_vsync ? 2'd0 : (den_fall && y_cnt_q != 2'd2) ? y_cnt_q + 2'd1 : y_cnt_q;
  assign s0_in_buf = s0_x_q < X_LIM;
  assign ra        = s0_x_q[RAM_AW-1:0];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x_q           <= '0;
      y_cnt_q       <= '0;
      y_par_q       <= 1'b0;
      pat_q         <= '0;
      s0_vs_q       <= 1'b0;
      s0_hs_q       <= 1'b0;
      s0_den_q      <= 1'b0;
      s0_raw_q      <= '0;
      s0_x_q        <= '0;
      s0_ypar_q     <= 1'b0;
      s0_yok_q      <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_den_q      <= 1'b0;
      s1_raw_q      <= '0;
      s1_ok_q       <= 1'b0;
      s1_ovf_q      <= 1'b0;
      s1_par_q      <= '0;
      out_vsync     <= 1'b0;
      out_hsync     <= 1'b0;
      out_den       <= 1'b0;
      out_data_R    <= '0;
      out_data_G    <= '0;
      out_data_B    <= '0;
      line_overflow <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_cnt_q       <= y_cnt_d;
      y_par_q       <= y_par_d;
      pat_q         <= (in_vsync && !s0_vs_q) ? cfg_pattern : pat_q;
      s0_vs_q       <= in_vsync;
      s0_hs_q       <= in_hsync;
      s0_den_q      <= in_den;
      s0_raw_q      <= in_raw;
      s0_x_q        <= x_q;
      s0_ypar_q     <= y_par_q;
      s0_yok_q      <= y_cnt_q == 2'd2;
      s1_vs_q       <= s0_vs_q;
      s1_hs_q       <= s0_hs_q;
      s1_den_q      <= s0_den_q;
      s1_raw_q      <= s0_raw_q;
      s1_ok_q       <= s0_yok_q && s0_x_q >= ADDR_W'(2) && s0_in_buf;
      s1_ovf_q      <= s0_den_q && !s0_in_buf;
      s1_par_q      <= {!s0_ypar_q, !s0_x_q[0]};
      out_vsync     <= s1_vs_q;
      out_hsync     <= s1_hs_q;
      out_den       <= s1_den_q;
      out_data_R    <= valid ? r_d : '0;
      out_data_G    <= valid ? g_d : '0;
      out_data_B    <= valid ? b_d : '0;
      line_overflow <= s1_vs_q && (line_overflow || s1_ovf_q);
    end

  // read-first line buffers: lb1 inherits the row lb0 held before this write
  always_ff @(posedge clk) begin
    if (s0_in_buf) begin
      rd0_q <= lb0[ra];
      rd1_q <= lb1[ra];
    end
    if (s0_den_q && s0_in_buf) begin
      lb0[ra] <= s0_raw_q;
      lb1[ra] <= lb0[ra];
    end
    if (s1_den_q) begin
      col0_q <= col1_q;
      col1_q <= col_new;
    end
  end

  assign col_new      = {rd1_q, rd0_q, s1_raw_q};
  assign {d0, w, d2}  = col0_q;
  assign {n, c, s}    = col1_q;
  assign {d1, e, d3}  = col_new;
  assign a_x  = DATA_W'(({2'b0, n} + {2'b0, s} + {2'b0, w} + {2'b0, e}) >> 2);
  assign a_d  = DATA_W'(({2'b0, d0} + {2'b0, d1} + {2'b0, d2} + {2'b0, d3}) >> 2);
  assign a_ns = DATA_W'(({1'b0, n} + {1'b0, s}) >> 1);
  assign a_we = DATA_W'(({1'b0, w} + {1'b0, e}) >> 1);
  assign site  = s1_par_q ^ pat_q;
  assign valid = s1_den_q && s1_ok_q;

  // site: 0=R 1=Gr 2=Gb 3=B
  always_comb begin
    r_d = site == 2'd0 ? c : site == 2'd1 ? a_we : site == 2'd2 ? a_ns : a_d;
    g_d = ^site ? c : a_x;
    b_d = site == 2'd0 ? a_d : site == 2'd1 ? a_ns : site == 2'd2 ? a_we : c;
  end
endmodule

// File: tb/tb_cfa_bilinear3x3.sv
// tb_cfa_bilinear3x3: stream-level checks against a frame-array reference model,
// plus hand-computed 3x3 vectors, latency, overflow and reset sequences.
module tb_cfa_bilinear3x3;
  localparam int IH = 16, AW = 5, MR = 16, MC = 40;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       in_vsync = 1'b0, in_hsync = 1'b0, in_den = 1'b0;
  logic [7:0] in_raw = 8'h0;
  logic [1:0] cfg_pattern = 2'd0;
  logic       out_vsync, out_hsync, out_den, line_overflow;
  logic [7:0] out_data_R, out_data_G, out_data_B;

  always #5 clk = ~clk;

  cfa_bilinear3x3 #(.DATA_W(8), .IMG_H(IH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
    .in_raw(in_raw), .cfg_pattern(cfg_pattern), .out_vsync(out_vsync), .out_hsync(out_hsync),
    .out_den(out_den), .out_data_R(out_data_R), .out_data_G(out_data_G), .out_data_B(out_data_B),
    .line_overflow(line_overflow)
  );

  typedef struct packed {logic vs, hs, den, ovf, inner; logic [23:0] rgb;} exp_t;
  typedef struct packed {logic [1:0] pat; logic [71:0] win; logic [23:0] rgb;} vec_t;

  exp_t        q[$];
  vec_t        tv[6];
  int          pix[MR][MC];
  int          pat_m;
  logic        ovf_m = 1'b0, flat_on = 1'b0;
  logic [23:0] flat_rgb, last_rgb;
  int          checks = 0, passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // bilinear reference straight from the frame array; centre is (r-1,c-1)
  function automatic logic [23:0] model(input int r, input int c);
    int ct, n, s, w, e, dg, x4, site, rr, gg, bb;
    if (r < 2 || c < 2 || c >= IH) return 24'h0;
    ct = pix[r-1][c-1]; n = pix[r-2][c-1]; s = pix[r][c-1];
    w = pix[r-1][c-2]; e = pix[r-1][c];
    dg = pix[r-2][c-2] + pix[r-2][c] + pix[r][c-2] + pix[r][c];
    x4 = n + s + w + e;
    site = ((((r - 1) % 2) * 2) + ((c - 1) % 2)) ^ pat_m;
    if (site == 0) begin rr = ct; gg = x4 / 4; bb = dg / 4; end
    else if (site == 1) begin rr = (w + e) / 2; gg = ct; bb = (n + s) / 2; end
    else if (site == 2) begin rr = (n + s) / 2; gg = ct; bb = (w + e) / 2; end
    else begin rr = dg / 4; gg = x4 / 4; bb = ct; end
    return {8'(rr), 8'(gg), 8'(bb)};
  endfunction

  task automatic step(input logic vs, input logic hs, input logic den, input int r, input int c);
    exp_t e;
    in_vsync = vs; in_hsync = hs; in_den = den;
    in_raw = den ? 8'(pix[r][c]) : 8'h0;
    if (!vs) ovf_m = 1'b0;
    else if (den && c >= IH) ovf_m = 1'b1;
    e.vs = vs; e.hs = hs; e.den = den; e.ovf = ovf_m;
    e.rgb = den ? model(r, c) : 24'h0;
    e.inner = den && r >= 2 && c >= 2 && c < IH;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      check("stream", {4'h0, out_vsync, out_hsync, out_den, line_overflow, out_data_R, out_data_G, out_data_B},
            {4'h0, e.vs, e.hs, e.den, e.ovf, e.rgb});
      if (flat_on && e.inner) check("flat", {8'h0, out_data_R, out_data_G, out_data_B}, {8'h0, flat_rgb});
      if (e.den) last_rgb = {out_data_R, out_data_G, out_data_B};
    end
  endtask

  task automatic run_rows(input int rows, input int cols, input int chg_row, input logic [1:0] cfg_mid);
    for (int r = 0; r < rows; r++) begin
      if (r == chg_row) cfg_pattern = cfg_mid;
      step(1, 1, 0, 0, 0);
      for (int c = 0; c < cols; c++) step(1, 1, 1, r, c);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
    end
  endtask

  task automatic run_frame(input int rows, input int cols, input logic [1:0] p,
                           input logic [1:0] cfg_mid, input int chg_row);
    cfg_pattern = p; pat_m = int'(p);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    run_rows(rows, cols, chg_row, cfg_mid);
    repeat (4) step(0, 0, 0, 0, 0);
  endtask

  task automatic fill_random(input int rows, input int cols);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) pix[r][c] = int'($urandom_range(0, 255));
  endtask

  initial begin
    int lat_d, lat_h, lat_v, den_n, idx;
    tv[0] = '{2'd3, 72'h04_01_04_00_09_01_04_01_05, 24'h09_00_04};
    tv[1] = '{2'd2, 72'h00_0A_00_FF_4D_FE_00_0B_00, 24'hFE_4D_0A};
    tv[2] = '{2'd1, 72'h09_C8_09_03_32_00_09_C9_09, 24'hC8_32_01};
    tv[3] = '{2'd0, 72'hFF_00_FF_03_80_00_FF_00_FE, 24'hFE_00_80};
    tv[4] = '{2'd3, 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF, 24'hFF_FF_FF};
    tv[5] = '{2'd0, 72'h01_02_01_02_07_02_00_02_01, 24'h00_02_07};

    #12;
    check("reset_out", {4'h0, out_vsync, out_hsync, out_den, line_overflow, out_data_R, out_data_G, out_data_B}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // single den pulse: latency of den and syncs
    in_vsync = 1; in_hsync = 1; in_den = 1; in_raw = 8'h55;
    lat_d = 0; lat_h = 0; lat_v = 0; den_n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      in_den = 0;
      if (out_den) den_n++;
      if (out_den && lat_d == 0) lat_d = k;
      if (out_hsync && lat_h == 0) lat_h = k;
      if (out_vsync && lat_v == 0) lat_v = k;
    end
    check("den_latency", 32'(lat_d), 32'd3);
    check("hsync_latency", 32'(lat_h), 32'd3);
    check("vsync_latency", 32'(lat_v), 32'd3);
    check("den_width", 32'(den_n), 32'd1);
    in_vsync = 0; in_hsync = 0;
    repeat (4) @(posedge clk);
    #1;

    // flat field
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) pix[r][c] = 100;
    flat_on = 1; flat_rgb = 24'h64_64_64;
    run_frame(8, 8, 2'd0, 2'd0, -1);

    // Bayer mosaics for every phase
    flat_rgb = {8'd200, 8'd100, 8'd50};
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          idx = (((r % 2) * 2) + (c % 2)) ^ p;
          pix[r][c] = idx == 0 ? 200 : idx == 3 ? 50 : 100;
        end
      run_frame(8, 8, 2'(p), 2'(p), -1);
    end
    flat_on = 0;

    // hand-computed single-window vectors (floor cases included)
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 9; k++) pix[k / 3][k % 3] = int'(tv[i].win[8*(8-k) +: 8]);
      last_rgb = 24'hxxxxxx;
      run_frame(3, 3, tv[i].pat, tv[i].pat, -1);
      check("vector", {8'h0, last_rgb}, {8'h0, tv[i].rgb});
    end

    // random frames, all phases
    for (int p = 0; p < 4; p++) begin
      fill_random(8, 8);
      run_frame(8, 8, 2'(p), 2'(p), -1);
    end

    // cfg change mid-frame is ignored until the next vsync rise
    fill_random(8, 8);
    run_frame(8, 8, 2'd0, 2'd3, 3);
    fill_random(8, 8);
    run_frame(8, 8, 2'd3, 2'd3, -1);

    // overlong lines, then lines long enough to saturate the column counter
    fill_random(4, IH + 4);
    run_frame(4, IH + 4, 2'd1, 2'd1, -1);
    check("ovf_cleared", {31'h0, line_overflow}, 32'h0);
    fill_random(4, MC);
    run_frame(4, MC, 2'd2, 2'd2, -1);

    // reset in the middle of a line
    fill_random(1, 8);
    cfg_pattern = 2'd2; pat_m = 2;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int c = 0; c < 5; c++) step(1, 1, 1, 0, c);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_out", {4'h0, out_vsync, out_hsync, out_den, line_overflow, out_data_R, out_data_G, out_data_B}, 32'h0);
    q.delete(); ovf_m = 1'b0;
    in_den = 0; in_hsync = 0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    fill_random(6, 8);
    run_rows(6, 8, -1, 2'd2);
    repeat (4) step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
